// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM (master) and the shared datapath (slave).
// Instruction fields and mem_ready flow in; step enables, mux selects and the debug state flow out.
interface multicycle_main_fsm_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       undef;
    logic       bus_err;
    logic [3:0] state;

    modport master (
        input  op, funct, mem_ready,
        output ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
               alu_op, reg_w, mem_w, branch, undef, bus_err, state
    );

    modport slave (
        output op, funct, mem_ready,
        input  ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
               alu_op, reg_w, mem_w, branch, undef, bus_err, state
    );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main sequencer of the multicycle ARM core; outputs decode from the state register in the same cycle.
// Fetch/memory states stall on mem_ready=0 and abort with a bus_err pulse after STALL_LIMIT+1 wait cycles.
module multicycle_main_fsm #(
    parameter int STALL_LIMIT = 15,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_main_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    state_t           cur;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;

    always_comb begin
        waiting = (cur inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !bus.mem_ready;
        timeout = (STALL_LIMIT != 0) && waiting && (wait_cnt == LIMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            // A wait cycle stays put unless it times out, so the counter only survives in-state waits
            wait_cnt <= (waiting && !timeout) ? wait_cnt + CNT_W'(1) : '0;
            case (cur)
                S_FETCH:    if (bus.mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        2'b01:   cur <= S_MEMADR;
                        2'b00:   cur <= bus.funct[5] ? S_EXECUTEI : S_EXECUTER;
                        2'b10:   cur <= S_BRANCH;
                        default: cur <= S_FETCH;
                    endcase
                end
                S_MEMADR:   cur <= bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: begin
                    if (bus.mem_ready)  cur <= S_MEMWB;
                    else if (timeout)   cur <= S_FETCH;
                end
                S_MEMWRITE: if (bus.mem_ready || timeout) cur <= S_FETCH;
                S_EXECUTER: cur <= S_ALUWB;
                S_EXECUTEI: cur <= S_ALUWB;
                default:    cur <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.ir_write   = 1'b0;
        bus.next_pc    = 1'b0;
        bus.adr_src    = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.result_src = 2'b00;
        bus.alu_op     = 1'b0;
        bus.reg_w      = 1'b0;
        bus.mem_w      = 1'b0;
        bus.branch     = 1'b0;
        case (cur)
            S_FETCH: begin
                bus.ir_write   = bus.mem_ready;
                bus.next_pc    = bus.mem_ready;
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
            end
            S_DECODE: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
            end
            S_MEMADR:   bus.alu_src_b = 2'b01;
            S_MEMREAD:  bus.adr_src   = 1'b1;
            S_MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                bus.mem_w   = 1'b1;
            end
            S_EXECUTER: bus.alu_op = 1'b1;
            S_EXECUTEI: begin
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 1'b1;
            end
            S_ALUWB:    bus.reg_w = 1'b1;
            S_BRANCH: begin
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                bus.branch     = 1'b1;
            end
            default: ;
        endcase
        // Enables drop the instant reset asserts, even before the state register settles
        bus.ir_write = bus.ir_write & reset;
        bus.next_pc  = bus.next_pc & reset;
        bus.reg_w    = bus.reg_w & reset;
        bus.mem_w    = bus.mem_w & reset;
        bus.branch   = bus.branch & reset;
        bus.undef    = reset && (cur == S_DECODE) && (bus.op == 2'b11);
        bus.bus_err  = reset && timeout;
        bus.state    = cur;
    end

endmodule
